savestate_bus_master: RTL and testbench

//  Initiator side of the savestate register bus. Every savestate responder (CPU, PPU, APU, mapper regs)

---
 rtl/savestate_bus_master_if.sv | 31 +++
 rtl/savestate_bus_master.sv | 165 ++++++++++++++++
 tb/tb_savestate_bus_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/savestate_bus_master_if.sv
// rtl/savestate_bus_master_if.sv - savestate sequencer control, responder bus and memory port bundle
interface savestate_bus_master_if;
    logic        save_start;
    logic        load_start;
    logic        busy;
    logic        done;
    logic        checksum_err;
    logic [9:0]  bus_adr;
    logic [63:0] bus_din;
    logic        bus_wren;
    logic        bus_rst;
    logic [63:0] bus_dout;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  save_start, load_start, bus_dout, mem_rdata, mem_ack,
        output busy, done, checksum_err, bus_adr, bus_din, bus_wren, bus_rst,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output save_start, load_start, bus_dout, mem_rdata, mem_ack,
        input  busy, done, checksum_err, bus_adr, bus_din, bus_wren, bus_rst,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/savestate_bus_master.sv
// rtl/savestate_bus_master.sv - savestate bus initiator walking responder indices to/from memory (option: SS_CHECKSUM_EN)
module savestate_bus_master #(
    parameter int NUM_REGS = 64,
    parameter int MEM_BASE = 0
) (
    input  logic clk,
    input  logic reset_n,
    savestate_bus_master_if.master bus
);
    localparam logic [9:0] LAST_IDX = 10'(NUM_REGS - 1);
    localparam logic [9:0] MBASE    = 10'(MEM_BASE);
`ifdef SS_CHECKSUM_EN
    localparam logic [9:0] CSUM_ADR = 10'(MEM_BASE + NUM_REGS);
`endif

`ifdef SS_CHECKSUM_EN
    typedef enum logic [3:0] {IDLE, LRST, SADR, SCAP, SMEM, LMEM, LWR, CSUM, FIN} state_t;
    logic        is_load;
    logic [63:0] csum;
`else
    typedef enum logic [3:0] {IDLE, LRST, SADR, SCAP, SMEM, LMEM, LWR, FIN} state_t;
    assign bus.checksum_err = 1'b0;
`endif

    state_t     state;
    logic [9:0] idx;

    // Sequencer: every bus/memory output is a register updated on state transitions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= 10'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.bus_adr   <= 10'd0;
            bus.bus_din   <= 64'd0;
            bus.bus_wren  <= 1'b0;
            bus.bus_rst   <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 10'd0;
            bus.mem_wdata <= 64'd0;
`ifdef SS_CHECKSUM_EN
            is_load          <= 1'b0;
            csum             <= 64'd0;
            bus.checksum_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // save has priority when both starts arrive together
                    if (bus.save_start) begin
                        state       <= SADR;
                        idx         <= 10'd0;
                        bus.bus_adr <= 10'd0;
                        bus.busy    <= 1'b1;
`ifdef SS_CHECKSUM_EN
                        is_load          <= 1'b0;
                        csum             <= 64'd0;
                        bus.checksum_err <= 1'b0;
`endif
                    end else if (bus.load_start) begin
                        state       <= LRST;
                        bus.bus_rst <= 1'b1;
                        bus.busy    <= 1'b1;
`ifdef SS_CHECKSUM_EN
                        is_load          <= 1'b1;
                        csum             <= 64'd0;
                        bus.checksum_err <= 1'b0;
`endif
                    end
                end
                LRST: begin
                    bus.bus_rst  <= 1'b0;
                    idx          <= 10'd0;
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= MBASE;
                    state        <= LMEM;
                end
                SADR: state <= SCAP;
                SCAP: begin
                    bus.mem_wdata <= bus.bus_dout;
`ifdef SS_CHECKSUM_EN
                    csum          <= csum ^ bus.bus_dout;
`endif
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= MBASE + idx;
                    state         <= SMEM;
                end
                SMEM: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (idx == LAST_IDX) begin
`ifdef SS_CHECKSUM_EN
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= CSUM_ADR;
                            bus.mem_wdata <= csum;
                            state         <= CSUM;
`else
                            bus.done <= 1'b1;
                            state    <= FIN;
`endif
                        end else begin
                            idx         <= idx + 10'd1;
                            bus.bus_adr <= idx + 10'd1;
                            state       <= SADR;
                        end
                    end
                end
                LMEM: begin
                    if (bus.mem_ack) begin
                        bus.mem_req  <= 1'b0;
                        bus.bus_din  <= bus.mem_rdata;
`ifdef SS_CHECKSUM_EN
                        csum         <= csum ^ bus.mem_rdata;
`endif
                        bus.bus_adr  <= idx;
                        bus.bus_wren <= 1'b1;
                        state        <= LWR;
                    end
                end
                LWR: begin
                    bus.bus_wren <= 1'b0;
                    if (idx == LAST_IDX) begin
`ifdef SS_CHECKSUM_EN
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= CSUM_ADR;
                        state        <= CSUM;
`else
                        bus.done <= 1'b1;
                        state    <= FIN;
`endif
                    end else begin
                        idx          <= idx + 10'd1;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= MBASE + idx + 10'd1;
                        state        <= LMEM;
                    end
                end
`ifdef SS_CHECKSUM_EN
                CSUM: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (is_load)
                            bus.checksum_err <= (bus.mem_rdata != csum);
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end
                end
`endif
                FIN: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_savestate_bus_master.sv
// tb/tb_savestate_bus_master.sv - scoreboard bench for savestate_bus_master save/load sequences
module tb_savestate_bus_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    savestate_bus_master_if ss_if();

    savestate_bus_master #(.NUM_REGS(64), .MEM_BASE(0)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ss_if)
    );

`ifdef SS_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [9:0]  adr;
        logic [63:0] data;
    } xact_t;

    xact_t       exp_mem[$];
    xact_t       exp_bus[$];
    xact_t       mx;
    xact_t       bx;
    logic [63:0] mem [0:1023];
    logic [63:0] load_exp [0:63];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rst_cnt = 0;
    int wren_cnt = 0;
    int ack_wait = 0;
    bit saving = 1'b0;
    bit ack_rand = 1'b0;
    bit stray_en = 1'b0;
    bit req_pending = 1'b0;
    logic [10:0] snap_ctl;
    logic [63:0] snap_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] resp_val(input logic [9:0] i);
        return (i == 10'd0) ? 64'hE064000000000000 : {54'h0, i};
    endfunction

    function automatic logic any_output();
        return |{ss_if.busy, ss_if.done, ss_if.checksum_err, ss_if.bus_adr, ss_if.bus_din,
                 ss_if.bus_wren, ss_if.bus_rst, ss_if.mem_req, ss_if.mem_we, ss_if.mem_addr,
                 ss_if.mem_wdata};
    endfunction

    // Responder model: data for the current index appears one cycle after bus_adr
    always @(posedge clk) ss_if.bus_dout <= resp_val(ss_if.bus_adr);

    // Memory model: acks after a (possibly random) delay, checks held request stability and written words
    always @(negedge clk) begin
        ss_if.mem_ack = 1'b0;
        if (reset_n && ss_if.mem_req) begin
            if (req_pending) begin
                chk("mem_ctl_stable", {53'h0, ss_if.mem_we, ss_if.mem_addr}, {53'h0, snap_ctl});
                if (ss_if.mem_we) chk("mem_wdata_stable", ss_if.mem_wdata, snap_wdata);
            end else begin
                snap_ctl   = {ss_if.mem_we, ss_if.mem_addr};
                snap_wdata = ss_if.mem_wdata;
                req_pending = 1'b1;
            end
            if (ack_wait == 0) begin
                ss_if.mem_ack   = 1'b1;
                ss_if.mem_rdata = mem[ss_if.mem_addr];
                if (ss_if.mem_we) begin
                    if (exp_mem.size() == 0) begin
                        chk("mem_write_unexpected", 64'd1, 64'd0);
                    end else begin
                        mx = exp_mem.pop_front();
                        chk("mem_write_addr", {54'h0, ss_if.mem_addr}, {54'h0, mx.adr});
                        chk("mem_write_data", ss_if.mem_wdata, mx.data);
                    end
                    mem[ss_if.mem_addr] = ss_if.mem_wdata;
                end
                req_pending = 1'b0;
                ack_wait = ack_rand ? int'($urandom_range(0, 5)) : 0;
            end else begin
                ack_wait--;
            end
        end else begin
            req_pending = 1'b0;
            if (stray_en && $urandom_range(0, 2) == 0) begin
                ss_if.mem_ack   = 1'b1;
                ss_if.mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Bus monitor: strobe rules, done counting and responder-write scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (ss_if.done) begin
                done_cnt++;
                chk("busy_at_done", {63'h0, ss_if.busy}, 64'd1);
            end
            if (ss_if.bus_rst) begin
                rst_cnt++;
                chk("rst_wren_exclusive", {63'h0, ss_if.bus_wren}, 64'd0);
            end
            if (saving && (ss_if.bus_wren || ss_if.bus_rst))
                chk("save_no_bus_strobes", 64'd1, 64'd0);
            if (ss_if.bus_wren) begin
                wren_cnt++;
                if (rst_cnt == 0) chk("wren_before_rst", 64'd1, 64'd0);
                if (exp_bus.size() == 0) begin
                    chk("bus_write_unexpected", 64'd1, 64'd0);
                end else begin
                    bx = exp_bus.pop_front();
                    chk("bus_write_adr", {54'h0, ss_if.bus_adr}, {54'h0, bx.adr});
                    chk("bus_write_din", ss_if.bus_din, bx.data);
                end
            end
        end
    end

    task automatic push_save();
        logic [63:0] x;
        x = 64'd0;
        for (int i = 0; i < 64; i++) begin
            exp_mem.push_back('{adr: 10'(i), data: resp_val(10'(i))});
            x ^= resp_val(10'(i));
        end
        if (CSUM_EN) exp_mem.push_back('{adr: 10'd64, data: x});
    endtask

    task automatic push_load();
        for (int i = 0; i < 64; i++)
            exp_bus.push_back('{adr: 10'(i), data: load_exp[i]});
    endtask

    task automatic start(input bit s, input bit l);
        @(negedge clk);
        ss_if.save_start = s;
        ss_if.load_start = l;
        @(negedge clk);
        ss_if.save_start = 1'b0;
        ss_if.load_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int c;
        c = 0;
        while (done_cnt == d0 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt == d0) chk({name, "_timeout"}, 64'd1, 64'd0);
        repeat (2) @(negedge clk);
        chk({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_busy_after"}, {63'h0, ss_if.busy}, 64'd0);
        chk({name, "_queues_empty"}, 64'(exp_mem.size() + exp_bus.size()), 64'd0);
    endtask

    task automatic run_load(input string name, input bit exp_err);
        int d0;
        push_load();
        rst_cnt = 0;
        wren_cnt = 0;
        d0 = done_cnt;
        start(1'b0, 1'b1);
        wait_done(d0, name);
        chk({name, "_rst_pulses"}, 64'(rst_cnt), 64'd1);
        chk({name, "_wren_pulses"}, 64'(wren_cnt), 64'd64);
        chk({name, "_checksum_err"}, {63'h0, ss_if.checksum_err}, {63'h0, exp_err});
    endtask

    task automatic run_save(input string name);
        int d0;
        push_save();
        saving = 1'b1;
        d0 = done_cnt;
        start(1'b1, 1'b0);
        wait_done(d0, name);
        saving = 1'b0;
    endtask

    initial begin
        int d0;
        int c;
        ss_if.save_start = 1'b0;
        ss_if.load_start = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
        for (int i = 0; i < 64; i++) load_exp[i] = resp_val(10'(i));

        repeat (3) @(negedge clk);
        chk("reset_outputs", {63'h0, any_output()}, 64'd0);
        reset_n = 1'b1;

        // immediate-ack save
        run_save("t1_save");
        chk("t1_mem0", mem[0], 64'hE064000000000000);
        chk("t1_mem63", mem[63], 64'd63);

        // load with word 6 altered
        mem[6] = 64'h0000000000000152;
        load_exp[6] = 64'h152;
        run_load("t2_load", CSUM_EN);
        load_exp[6] = resp_val(10'd6);

        // random ack latency plus stray acks while idle
        ack_rand = 1'b1;
        stray_en = 1'b1;
        ack_wait = int'($urandom_range(0, 5));
        run_save("t3_save");
        run_load("t3_load", 1'b0);
        ack_rand = 1'b0;
        stray_en = 1'b0;
        ack_wait = 0;

        // simultaneous starts, then a load_start mid-save
        push_save();
        saving = 1'b1;
        rst_cnt = 0;
        d0 = done_cnt;
        start(1'b1, 1'b1);
        repeat (50) @(negedge clk);
        ss_if.load_start = 1'b1;
        @(negedge clk);
        ss_if.load_start = 1'b0;
        wait_done(d0, "t4_save");
        saving = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_no_extra_done", 64'(done_cnt - d0), 64'd1);
        chk("t4_no_bus_rst", 64'(rst_cnt), 64'd0);
        chk("t4_idle_busy", {63'h0, ss_if.busy}, 64'd0);

        // reset during load at index 20, then a full load
        push_load();
        rst_cnt = 0;
        start(1'b0, 1'b1);
        c = 0;
        while (!(ss_if.bus_wren && ss_if.bus_adr == 10'd20) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reached_idx20", {54'h0, ss_if.bus_adr}, 64'd20);
        #2 reset_n = 1'b0;
        #1 chk("t5_reset_outputs", {63'h0, any_output()}, 64'd0);
        exp_bus.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_load("t5_reload", 1'b0);

        // checksum detection on a flipped bit in word 12
        run_save("t6_save");
        mem[12] = mem[12] ^ 64'd1;
        load_exp[12] = resp_val(10'd12) ^ 64'd1;
        run_load("t6_load", CSUM_EN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
